brubber_dl_ctrl: RTL and testbench

// - Sequences the HPS ROM download into the Burnin' Rubber core. Sits between hps_io ioctl_* and the core's ROM write port.
// - Decodes each byte to a ROM region and buffers writes in a 4-deep FIFO, so the core's write port may stall. Back-pressures the HPS with ioctl_wait.
// - Holds the game in reset during load and drain, then for a settle period, then releases it.

---
 rtl/brubber_dl_ctrl_pkg.sv | 42 ++++
 rtl/brubber_dl_ctrl_if.sv | 27 ++
 rtl/brubber_dl_ctrl_fifo.sv | 53 +++++
 rtl/brubber_dl_ctrl.sv | 131 +++++++++++++
 tb/tb_brubber_dl_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/brubber_dl_ctrl_pkg.sv
// Shared types and ROM map for the Burnin' Rubber download controller.
package brubber_dl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        HOLD  = 3'd3,
        RUN   = 3'd4
    } dl_state_t;

    typedef logic [1:0] region_t;

    localparam region_t REG_CPU  = 2'd0;
    localparam region_t REG_SND  = 2'd1;
    localparam region_t REG_GFX  = 2'd2;
    localparam region_t REG_PROM = 2'd3;

    // Regions are contiguous from address 0, so each one is bounded by its limit.
    localparam logic [24:0] CPU_LIMIT  = 25'h0FFFF;
    localparam logic [24:0] SND_LIMIT  = 25'h11FFF;
    localparam logic [24:0] GFX_LIMIT  = 25'h1BFFF;
    localparam logic [24:0] PROM_LIMIT = 25'h1C0FF;

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
        region_t     region;
    } dl_entry_t;

    function automatic logic addr_mapped(input logic [24:0] a);
        return a <= PROM_LIMIT;
    endfunction

    function automatic region_t addr_region(input logic [24:0] a);
        if (a <= CPU_LIMIT) return REG_CPU;
        if (a <= SND_LIMIT) return REG_SND;
        if (a <= GFX_LIMIT) return REG_GFX;
        return REG_PROM;
    endfunction

endpackage

// File: rtl/brubber_dl_ctrl_if.sv
// HPS ioctl download bus plus core ROM write port, as seen by the download controller.
interface brubber_dl_ctrl_if;
    import brubber_dl_pkg::*;

    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;

    logic        rom_req;
    logic        rom_ack;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    region_t     rom_region;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, rom_ack,
        input  ioctl_wait, rom_req, rom_addr, rom_data, rom_region
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, rom_ack,
        output ioctl_wait, rom_req, rom_addr, rom_data, rom_region
    );

endinterface

// File: rtl/brubber_dl_ctrl_fifo.sv
// Synchronous FIFO of download entries; push while full is accepted only alongside a pop.
module dl_fifo
    import brubber_dl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  dl_entry_t   push_data,
    input  logic        pop,
    output dl_entry_t   head,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    dl_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    always_comb begin
        full    = (count == (AW+1)'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/brubber_dl_ctrl.sv
// HPS ROM download sequencer for Burnin' Rubber: region decode, write buffering, core reset hold.
// Optional DL_CHECKSUM_EN adds dl_sum/dl_sum_valid (wrapping sum of accepted bytes).
module brubber_dl_ctrl
    import brubber_dl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned WAIT_LEVEL  = 3
) (
    input  logic               clk_sys,
    input  logic               reset,
    brubber_dl_ctrl_if.slave   bus,
    output logic               core_reset,
`ifdef DL_CHECKSUM_EN
    output logic [15:0]        dl_sum,
    output logic               dl_sum_valid,
`endif
    output logic [15:0]        drop_cnt
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

    dl_state_t      state;
    dl_state_t      state_nxt;
    logic [HW-1:0]  hold_cnt;

    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic           full;
    logic           empty;
    dl_entry_t      head;
    dl_entry_t      wr_entry;

    logic           strobe;
    logic           mapped;
    logic           push;
    logic           pop;
    logic           drop;
    logic           rom_req_nxt;

    logic           rom_req_q;
    logic           wait_q;
    dl_entry_t      rom_q;

    always_comb begin
        strobe      = bus.ioctl_wr && bus.ioctl_download;
        mapped      = addr_mapped(bus.ioctl_addr);
        pop         = !empty && (!rom_req_q || bus.rom_ack);
        push        = strobe && mapped && (!full || pop);
        drop        = strobe && !push;
        count_nxt   = count + CW'(push) - CW'(pop);
        rom_req_nxt = pop || (rom_req_q && !bus.rom_ack);
        wr_entry    = '{addr: bus.ioctl_addr[16:0], data: bus.ioctl_dout,
                        region: addr_region(bus.ioctl_addr)};
    end

    dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk_sys),
        .reset     (reset),
        .push      (push),
        .push_data (wr_entry),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // DRAIN looks at next-cycle FIFO/req state so HOLD starts on the final ack edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.ioctl_download) state_nxt = LOAD;
            LOAD:    if (!bus.ioctl_download) state_nxt = DRAIN;
            DRAIN:   if (count_nxt == '0 && !rom_req_nxt) state_nxt = HOLD;
            HOLD: begin
                if (bus.ioctl_download)  state_nxt = LOAD;
                else if (hold_cnt == '0) state_nxt = RUN;
            end
            RUN:     if (bus.ioctl_download) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        core_reset = !(state == RUN && !bus.ioctl_download);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            rom_req_q <= 1'b0;
            rom_q     <= '0;
            wait_q    <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == DRAIN && state_nxt == HOLD)
                hold_cnt <= HW'(HOLD_CYCLES - 1);
            else if (state == HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;
            rom_req_q <= rom_req_nxt;
            if (pop) rom_q <= head;
            wait_q <= (count_nxt >= CW'(WAIT_LEVEL));
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign bus.rom_req    = rom_req_q;
    assign bus.rom_addr   = rom_q.addr;
    assign bus.rom_data   = rom_q.data;
    assign bus.rom_region = rom_q.region;
    assign bus.ioctl_wait = wait_q;

`ifdef DL_CHECKSUM_EN
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_sum <= '0;
        end else if (state_nxt == LOAD && state != LOAD) begin
            dl_sum <= push ? {8'h00, bus.ioctl_dout} : '0;
        end else if (push) begin
            dl_sum <= dl_sum + {8'h00, bus.ioctl_dout};
        end
    end

    assign dl_sum_valid = (state == HOLD) || (state == RUN);
`endif

endmodule

// File: tb/tb_brubber_dl_ctrl.sv
// Randomized self-checking bench for brubber_dl_ctrl against a transaction-level model.
module tb_brubber_dl_ctrl;

    localparam int HOLD = 32;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        core_reset;
    logic [15:0] drop_cnt;
`ifdef DL_CHECKSUM_EN
    logic [15:0] dl_sum;
    logic        dl_sum_valid;
`endif

    brubber_dl_ctrl_if bus();

    brubber_dl_ctrl #(.HOLD_CYCLES(HOLD), .FIFO_DEPTH(4), .WAIT_LEVEL(3)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .bus          (bus),
        .core_reset   (core_reset),
`ifdef DL_CHECKSUM_EN
        .dl_sum       (dl_sum),
        .dl_sum_valid (dl_sum_valid),
`endif
        .drop_cnt     (drop_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int a;
        int d;
        int r;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    exp_drop = 0;
    int    exp_sum = 0;
    int    cyc = 0;
    int    last_xfer_edge = 0;
    bit    dl_lvl = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference ROM map: contiguous cpu/snd/gfx/prom regions from address 0.
    function automatic bit is_mapped(input int a);
        return (a >= 0) && (a <= 'h1C0FF);
    endfunction

    function automatic int region_of(input int a);
        if (a < 'h10000) return 0;
        if (a < 'h12000) return 1;
        if (a < 'h1C000) return 2;
        return 3;
    endfunction

    function automatic int rand_unmapped();
        int sel;
        sel = $urandom_range(0, 1);
        if (sel == 0) return $urandom_range('h1C100, 'h1FFFF);
        return $urandom_range('h20000, 'h1FFFFFF);
    endfunction

    // One clock: drive inputs at the negedge, score the handshake, advance to the next negedge.
    task automatic tick(input bit wr, input int a, input int d, input bit ack, input bit ign_full);
        xfer_t e;
        bus.ioctl_download = dl_lvl;
        bus.ioctl_wr       = wr;
        bus.ioctl_addr     = 25'(a);
        bus.ioctl_dout     = 8'(d);
        bus.rom_ack        = ack;
        if (bus.rom_req && ack) begin
            check_eq("req_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("rom_addr", 32'(bus.rom_addr), 32'(e.a));
                check_eq("rom_data", 32'(bus.rom_data), 32'(e.d));
                check_eq("rom_region", 32'(bus.rom_region), 32'(e.r));
            end
            last_xfer_edge = cyc + 1;
        end
        if (wr && dl_lvl) begin
            if (!is_mapped(a) || ign_full) begin
                exp_drop++;
            end else begin
                exp_q.push_back('{a & 'h1FFFF, d & 'hFF, region_of(a)});
                exp_sum = (exp_sum + (d & 'hFF)) & 'hFFFF;
            end
        end
        @(posedge clk_sys);
        cyc++;
        @(negedge clk_sys);
    endtask

    task automatic send(input int a, input int d, input bit rnd_ack);
        int k;
        k = 0;
        while (bus.ioctl_wait && k < 200) begin
            tick(1'b0, 0, 0, rnd_ack ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0);
            k++;
        end
        if (k == 200) check_eq("wait_release", 32'(bus.ioctl_wait), 0);
        tick(1'b1, a, d, rnd_ack ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || bus.rom_req) && k < budget) begin
            tick(1'b0, 0, 0, 1'b1, 1'b0);
            k++;
        end
        check_eq("drain_left", 32'(exp_q.size()), 0);
        check_eq("drain_req", 32'(bus.rom_req), 0);
    endtask

    task automatic wait_run();
        int k;
        k = 0;
        while (core_reset && k < HOLD + 50) begin
            tick(1'b0, 0, 0, 1'b1, 1'b0);
            k++;
        end
        check_eq("run_reached", 32'(core_reset), 0);
    endtask

    task automatic start_download();
        dl_lvl  = 1'b1;
        exp_sum = 0;
        tick(1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int k;
        int bnd[15];

        reset              = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.rom_ack        = 1'b0;
        repeat (3) @(negedge clk_sys);

        check_eq("rst_rom_req", 32'(bus.rom_req), 0);
        check_eq("rst_wait", 32'(bus.ioctl_wait), 0);
        check_eq("rst_core_reset", 32'(core_reset), 1);
        check_eq("rst_drop_cnt", 32'(drop_cnt), 0);
        check_eq("rst_rom_addr", 32'(bus.rom_addr), 0);
        check_eq("rst_rom_data", 32'(bus.rom_data), 0);
        check_eq("rst_rom_region", 32'(bus.rom_region), 0);
        reset = 1'b0;
        tick(1'b0, 0, 0, 1'b0, 1'b0);
        check_eq("idle_core_reset", 32'(core_reset), 1);

        // Region boundaries with ack tied high, then the hold period after the last ack.
        bnd = '{'h0, 'h1, 'hFFFE, 'hFFFF, 'h10000, 'h10001, 'h11FFE, 'h11FFF,
                'h12000, 'h12001, 'h1BFFF, 'h1C000, 'h1C001, 'h1C0FE, 'h1C0FF};
        start_download();
`ifdef DL_CHECKSUM_EN
        check_eq("sum_valid_load", 32'(dl_sum_valid), 0);
`endif
        foreach (bnd[i]) send(bnd[i], $urandom_range(0, 255), 1'b0);
        for (int i = 0; i < 40; i++) send($urandom_range(0, 'h1C0FF), $urandom_range(0, 255), 1'b0);
        dl_lvl = 1'b0;
        drain(100);
        check_eq("drop_boundary", 32'(drop_cnt), 32'(exp_drop));
        check_eq("hold_core_reset", 32'(core_reset), 1);
`ifdef DL_CHECKSUM_EN
        check_eq("sum_valid_hold", 32'(dl_sum_valid), 1);
        check_eq("sum_boundary", 32'(dl_sum), 32'(exp_sum));
`endif
        k = 0;
        while (core_reset && k < HOLD + 20) begin
            tick(1'b0, 0, 0, 1'b1, 1'b0);
            k++;
        end
        check_eq("hold_len", 32'(cyc - last_xfer_edge), 32'(HOLD));

        // New download from RUN reasserts core_reset combinationally, then a 20-cycle ack stall.
        check_eq("run_core_reset", 32'(core_reset), 0);
        bus.ioctl_download = 1'b1;
        #1;
        check_eq("redl_core_reset", 32'(core_reset), 1);
        start_download();
        for (int i = 0; i < 10; i++) send($urandom_range(0, 'h1C0FF), $urandom_range(0, 255), 1'b0);
        for (int i = 0; i < 20; i++)
            tick(!bus.ioctl_wait, $urandom_range(0, 'h1C0FF), $urandom_range(0, 255), 1'b0, 1'b0);
        check_eq("stall_wait", 32'(bus.ioctl_wait), 1);
        check_eq("stall_outstanding", 32'(exp_q.size()), 4);
        for (int i = 0; i < 10; i++) send($urandom_range(0, 'h1C0FF), $urandom_range(0, 255), 1'b0);
        dl_lvl = 1'b0;
        drain(100);
        check_eq("drop_stall", 32'(drop_cnt), 32'(exp_drop));

        // Random traffic: mixed mapped/unmapped bytes, random ack, then strobes outside the window.
        wait_run();
        start_download();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) send(rand_unmapped(), $urandom_range(0, 255), 1'b1);
            else send($urandom_range(0, 'h1C0FF), $urandom_range(0, 255), 1'b1);
        end
        dl_lvl = 1'b0;
        for (int i = 0; i < 20; i++)
            tick(1'b1, $urandom_range(0, 'h1FFFF), $urandom_range(0, 255), 1'b1, 1'b0);
        drain(200);
        check_eq("drop_random", 32'(drop_cnt), 32'(exp_drop));
`ifdef DL_CHECKSUM_EN
        check_eq("sum_random", 32'(dl_sum), 32'(exp_sum));
`endif

        // Out-of-map bytes: end of map, top of 17-bit space, high address bit set.
        wait_run();
        start_download();
        send('h1C100, 'h5A, 1'b0);
        send('h1FFFF, 'hA5, 1'b0);
        send('h100000 | $urandom_range(0, 'hFFFF), 'h3C, 1'b0);
        repeat (6) tick(1'b0, 0, 0, 1'b1, 1'b0);
        check_eq("drop_oob", 32'(drop_cnt), 32'(exp_drop));
        check_eq("oob_req", 32'(bus.rom_req), 0);

        // Wait ignored with ack held low: one entry on the port, four buffered, two dropped.
        for (int i = 0; i < 7; i++)
            tick(1'b1, 'h12000 + i, $urandom_range(0, 255), 1'b0, i >= 5);
        check_eq("full_wait", 32'(bus.ioctl_wait), 1);
        check_eq("drop_full", 32'(drop_cnt), 32'(exp_drop));
        drain(50);

        // Reset in the middle of a load with three entries queued behind the port.
        for (int i = 0; i < 4; i++)
            tick(1'b1, $urandom_range(0, 'h1C0FF), $urandom_range(0, 255), 1'b0, 1'b0);
        check_eq("pre_rst_wait", 32'(bus.ioctl_wait), 1);
        reset = 1'b1;
        tick(1'b0, 0, 0, 1'b0, 1'b0);
        check_eq("midrst_rom_req", 32'(bus.rom_req), 0);
        check_eq("midrst_core_reset", 32'(core_reset), 1);
        check_eq("midrst_wait", 32'(bus.ioctl_wait), 0);
        check_eq("midrst_drop_cnt", 32'(drop_cnt), 0);
        exp_q.delete();
        exp_drop = 0;
        reset  = 1'b0;
        dl_lvl = 1'b0;
        repeat (10) tick(1'b0, 0, 0, 1'b1, 1'b0);
        check_eq("midrst_idle", 32'(core_reset), 1);
        check_eq("midrst_no_req", 32'(bus.rom_req), 0);

`ifdef DL_CHECKSUM_EN
        start_download();
        for (int i = 0; i < 300; i++) send('h12000 + i, 'hFF, 1'b0);
        dl_lvl = 1'b0;
        drain(100);
        check_eq("sum_ff_valid", 32'(dl_sum_valid), 1);
        check_eq("sum_ff", 32'(dl_sum), 32'(exp_sum));
        wait_run();
        check_eq("sum_valid_run", 32'(dl_sum_valid), 1);
        bus.ioctl_download = 1'b1;
        start_download();
        for (int i = 0; i < 5; i++) send($urandom_range(0, 'h1C0FF), $urandom_range(0, 255), 1'b0);
        dl_lvl = 1'b0;
        drain(50);
        check_eq("sum_restart", 32'(dl_sum), 32'(exp_sum));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
